// File: rtl/sm_cfg_pkg.sv
// Shared constants, state type and legality helper
// for the switch_matrix configuration loader.
package sm_cfg_pkg;

    localparam int CHANNEL_WIDTH = 8;
    localparam int WORD_W        = 8;
    localparam int SIDES         = 4;
    localparam int MUX_PER_SIDE  = CHANNEL_WIDTH / 2;
    localparam int SEL_W         = 2;
    localparam int NUM_SEL       = SIDES * MUX_PER_SIDE;
    localparam int CFG_BITS      = NUM_SEL * SEL_W;
    localparam int NUM_WORDS     = CFG_BITS / WORD_W;
    localparam int CNT_W         = (NUM_WORDS > 1) ?
                                   $clog2(NUM_WORDS) : 1;

    localparam logic [SEL_W-1:0] SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_t;

    // Matrix outputs are 3-input muxes, so select 2'b11
    // has no source; any such field rejects the image.
    function automatic logic sel_legal(
        input logic [CFG_BITS-1:0] cfg
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (cfg[i*SEL_W +: SEL_W] == SEL_INVALID) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/sm_config_ctrl.sv
// Config image loader for one switch_matrix tile:
// stream into a shadow, check, commit atomically.
module sm_config_ctrl
    import sm_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_valid,
    input  logic [WORD_W-1:0]   cfg_data,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] cfg_active,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                loaded
);

    localparam logic [CNT_W-1:0] LAST_WORD =
        CNT_W'(NUM_WORDS - 1);

    cfg_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                loaded_q, loaded_d;

    // Next-state: word intake, abort, one-cycle check/commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[cnt_q*WORD_W +: WORD_W] = cfg_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (sel_legal(shadow_q)) begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, async active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
        end
    end

    assign cfg_ready  = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign cfg_active = active_q;
    assign done       = done_q;
    assign err        = err_q;
    assign loaded     = loaded_q;

endmodule
